wave_analyzer: RTL and testbench
================================

# wave_analyzer

Measurement block at the receiving end of the waveform generator's sample stream. It takes signed 16-bit samples, detects rising zero crossings with hysteresis, and measures one full period. Per period it reports the period length, high time, maximum, minimum and peak-to-peak amplitude, so generator output can be checked on-chip or in the bench without a scope.

## Interface
- `HYST`, 16: hysteresis threshold (positive, < 2^15). A sample ≥ +HYST is high; a sample ≤ −HYST is low.
- `CNT_W`, 16: width of the period and high-time counters.
- `MAX_PERIOD`, 2^CNT_W−1: sample count at which the timeout fires.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst`  in  1  asynchronous reset, active-low.
- `sample_in`  in  16 signed  input sample.
- `sample_valid`  in  1  `sample_in` is valid this cycle.
- `start`  in  1  one-cycle request to begin a measurement. Ignored unless in IDLE.
- `abort`  in  1  return to IDLE. No results are updated.
- `cont`  in  1  continuous mode, sampled at each closing crossing.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when new results are valid.
- `timeout`  out  1  one-cycle pulse when no crossing is seen within MAX_PERIOD samples.
- `period`  out  CNT_W  samples from one rising crossing to the next.
- `high_cnt`  out  CNT_W  number of samples in the period that are high after hysteresis.
- `peak_max`  out  16 signed  maximum sample in the period.
- `peak_min`  out  16 signed  minimum sample in the period.
- `amp_pp`  out  17 unsigned  `peak_max − peak_min`.

## Operation
- **Hysteresis state `lvl`:**
  - Updated only on valid samples: ≥ +HYST sets it to 1, ≤ −HYST clears it to 0, anything between holds it.
  - Reset value is 1. The first crossing therefore needs a low sample first.
  - It updates in every FSM state.
- **Rising crossing:** a valid sample that moves `lvl` from 0 to 1.
- **IDLE:**
  - `start` goes to ARM and clears the sample counter.
  - `abort` has priority over `start` in every state.
- **ARM:**
  - Each valid sample increments the sample counter.
  - On a rising crossing, go to MEASURE. Load period count = 1, high count = 1, max = min = the crossing sample.
  - If the counter reaches MAX_PERIOD first, pulse `timeout` and go to IDLE.
- **MEASURE, each valid sample that is not a rising crossing:**
  - Period count +1.
  - High count +1 if the updated `lvl` = 1.
  - max/min update with signed compare.
- **MEASURE, valid rising crossing (the closing crossing):**
  - Latch `period`, `high_cnt`, `peak_max`, `peak_min` and `amp_pp` from the accumulators. The closing sample is excluded from these results.
  - Pulse `done`.
  - If `cont` = 1, stay in MEASURE and reload the accumulators from the closing sample, exactly as in the ARM entry. Otherwise go to IDLE.
- **MEASURE timeout:** if the period count reaches MAX_PERIOD, pulse `timeout`, go to IDLE and leave the result registers unchanged.
- **Sample gaps:** cycles with `sample_valid` = 0 change nothing except `abort` handling.
- **Arithmetic:**
  - `amp_pp` is computed at 17 bits, so it has no overflow. The range is 0…65535.
  - Counters never wrap, because the timeout fires at MAX_PERIOD.

## Timing
- **Reset values:**
  - State IDLE, `lvl` = 1.
  - `busy`, `done` and `timeout` = 0.
  - All result outputs = 0.
  - Accumulators = 0.
- **`done` / results:** on the clock edge that samples the closing crossing, `done` is asserted for exactly one cycle and the results update. Latency is 1 cycle from the sample being presented. Results hold until the next `done`.
- **`timeout`:** asserted for one cycle on the edge that samples the MAX_PERIOD-th sample.
- **`busy`:** rises on the edge after `start` is sampled in IDLE. It falls on the edge after the closing crossing (non-continuous mode), after the timeout, or after `abort`.
- **`abort` together with a closing crossing:** `abort` wins. No `done` is produced.
- **`start` while busy:** ignored.
- **Reset mid-measurement:** immediate return to reset values, no `done`.

## Test plan
- **Basic square wave:** `start`, then a square wave of +100 for 10 samples and −100 for 10 samples (HYST = 16). First `done` gives `period` = 20, `high_cnt` = 10, `peak_max` = 100, `peak_min` = −100, `amp_pp` = 200.
- **Hysteresis rejection:** ±10 noise between crossings of ±1000, period 32. Noise causes no extra crossings, and `period` = 32 on every `done`.
- **Timeout:** MAX_PERIOD = 64 and a constant input of 0 after `start`. `timeout` pulses exactly at the 64th valid sample, results stay unchanged, and `busy` = 0.
- **Gaps and continuous mode:** the same 20-sample wave with `sample_valid` = 0 on every other cycle, and `cont` = 1. `done` repeats every 20 valid samples with `period` = 20 and no lost period.
- **Full-scale input:** a wave between −32768 and +32767 gives `amp_pp` = 65535.
- **Abort and reset mid-measurement:**
  - `abort` in MEASURE, including on a closing-crossing cycle: no `done`, IDLE next cycle.
  - `rst` low mid-MEASURE: all outputs read 0 immediately.

Source files
------------

// File: rtl/wave_analyzer.sv
// wave_analyzer: hysteresis zero-crossing detector and single-period meter.
// Ports: clk, rst (async low), sample_in/sample_valid, start/abort/cont
//        controls; busy/done/timeout status; period, high_cnt, peak_max,
//        peak_min, amp_pp results (held until the next done).
module wave_analyzer #(
    parameter int          HYST       = 16,
    parameter int          CNT_W      = 16,
    parameter int unsigned MAX_PERIOD = (1 << CNT_W) - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [15:0]      sample_in,
    input  logic                    sample_valid,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cont,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic        [CNT_W-1:0] period,
    output logic        [CNT_W-1:0] high_cnt,
    output logic signed [15:0]      peak_max,
    output logic signed [15:0]      peak_min,
    output logic        [16:0]      amp_pp
);

    localparam logic signed [15:0] HI_TH = 16'(HYST);
    localparam logic signed [15:0] LO_TH = -HI_TH;
    localparam logic [CNT_W-1:0]   MAX_P = CNT_W'(MAX_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    state_t                   state;
    logic                     lvl;
    logic                     lvl_nx;
    logic                     rise;
    logic        [CNT_W-1:0]  cnt;
    logic        [CNT_W-1:0]  cnt_inc;
    logic        [CNT_W-1:0]  hcnt;
    logic signed [15:0]       acc_max;
    logic signed [15:0]       acc_min;
    logic        [16:0]       diff;

    always_comb begin
        lvl_nx = lvl;
        if (sample_valid) begin
            if (sample_in >= HI_TH) begin
                lvl_nx = 1'b1;
            end else if (sample_in <= LO_TH) begin
                lvl_nx = 1'b0;
            end
        end
    end

    assign rise    = sample_valid & ~lvl & lvl_nx;
    assign cnt_inc = cnt + 1'b1;
    // Sign-extend both peaks so the difference cannot overflow.
    assign diff    = {acc_max[15], acc_max} - {acc_min[15], acc_min};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lvl      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            period   <= '0;
            high_cnt <= '0;
            peak_max <= '0;
            peak_min <= '0;
            amp_pp   <= '0;
            cnt      <= '0;
            hcnt     <= '0;
            acc_max  <= '0;
            acc_min  <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            lvl     <= lvl_nx;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state <= ARM;
                            busy  <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                    ARM: begin
                        if (rise) begin
                            state   <= MEAS;
                            cnt     <= CNT_W'(1);
                            hcnt    <= CNT_W'(1);
                            acc_max <= sample_in;
                            acc_min <= sample_in;
                        end else if (sample_valid) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == MAX_P) begin
                                timeout <= 1'b1;
                                state   <= IDLE;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            // Closing crossing: report, then optionally
                            // reopen on this same sample.
                            period   <= cnt;
                            high_cnt <= hcnt;
                            peak_max <= acc_max;
                            peak_min <= acc_min;
                            amp_pp   <= diff;
                            done     <= 1'b1;
                            if (cont) begin
                                cnt     <= CNT_W'(1);
                                hcnt    <= CNT_W'(1);
                                acc_max <= sample_in;
                                acc_min <= sample_in;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (sample_valid) begin
                            cnt <= cnt_inc;
                            if (lvl_nx) begin
                                hcnt <= hcnt + 1'b1;
                            end
                            if (sample_in > acc_max) begin
                                acc_max <= sample_in;
                            end
                            if (sample_in < acc_min) begin
                                acc_min <= sample_in;
                            end
                            if (cnt_inc == MAX_P) begin
                                timeout <= 1'b1;
                                state   <= IDLE;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wave_analyzer.sv
// tb_wave_analyzer: scoreboard bench for wave_analyzer.
// Expected results are queued when a closing crossing is driven.
module tb_wave_analyzer;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               sample_valid = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               cont = 1'b0;
    logic               busy;
    logic               done;
    logic               timeout;
    logic        [15:0] period;
    logic        [15:0] high_cnt;
    logic signed [15:0] peak_max;
    logic signed [15:0] peak_min;
    logic        [16:0] amp_pp;

    typedef struct {
        logic        [15:0] per;
        logic        [15:0] hi;
        logic signed [15:0] mx;
        logic signed [15:0] mn;
        logic        [16:0] amp;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   errors = 0;
    int   checks = 0;
    int   dones  = 0;

    wave_analyzer #(
        .HYST(16),
        .CNT_W(16),
        .MAX_PERIOD(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .start(start),
        .abort(abort),
        .cont(cont),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .period(period),
        .high_cnt(high_cnt),
        .peak_max(peak_max),
        .peak_min(peak_min),
        .amp_pp(amp_pp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst && done) begin
            exp_t e;
            dones++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got period=%0d, no result queued",
                         period);
            end else begin
                e = sb.pop_front();
                last_e = e;
                if ({period, high_cnt, peak_max, peak_min, amp_pp} !==
                    {e.per, e.hi, e.mx, e.mn, e.amp}) begin
                    errors++;
                    $display("FAIL result: got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                             period, high_cnt, peak_max, peak_min, amp_pp,
                             e.per, e.hi, e.mx, e.mn, e.amp);
                end
            end
        end
    end

    task automatic send(input logic signed [15:0] v, input bit gap);
        if (gap) begin
            @(negedge clk);
            sample_valid = 1'b0;
            sample_in    = 16'sh7fff;
        end
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            sample_in    = '0;
            abort        = 1'b0;
            start        = 1'b0;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        sample_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
    endtask

    task automatic do_abort();
        @(negedge clk);
        sample_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_abort: got %b want 0", busy);
        end
    endtask

    task automatic gen_period(input logic signed [15:0] hv,
                              input logic signed [15:0] lv,
                              input int half, input bit noisy,
                              input bit gap, input bit closing);
        exp_t e;
        int   q;
        e.per = 16'(2 * half);
        e.hi  = 16'(half);
        e.mx  = hv;
        e.mn  = lv;
        e.amp = 17'(int'(hv) - int'(lv));
        if (closing) sb.push_back(e);
        q = half / 2;
        if (noisy) begin
            for (int i = 0; i < q; i++) send(hv, gap);
            for (int i = 0; i < q; i++)
                send(16'(int'($urandom_range(20)) - 10), gap);
            for (int i = 0; i < q; i++) send(lv, gap);
            for (int i = 0; i < q; i++)
                send(16'(int'($urandom_range(20)) - 10), gap);
        end else begin
            for (int i = 0; i < half; i++) send(hv, gap);
            for (int i = 0; i < half; i++) send(lv, gap);
        end
    endtask

    task automatic measure(input logic signed [15:0] hv,
                           input logic signed [15:0] lv,
                           input int half, input bit noisy,
                           input bit gap, input int nper);
        exp_t e;
        for (int i = 0; i < half; i++) send(lv, gap);
        for (int k = 0; k < nper; k++)
            gen_period(hv, lv, half, noisy, gap, k > 0);
        e.per = 16'(2 * half);
        e.hi  = 16'(half);
        e.mx  = hv;
        e.mn  = lv;
        e.amp = 17'(int'(hv) - int'(lv));
        sb.push_back(e);
        send(hv, gap);
    endtask

    task automatic check_dones(input string name, input int want);
        checks++;
        if (dones !== want || sb.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d dones (%0d pending) want %0d",
                     name, dones, sb.size(), want);
        end
    endtask

    task automatic check_held(input string name);
        checks++;
        if ({period, high_cnt, peak_max, peak_min, amp_pp} !==
            {last_e.per, last_e.hi, last_e.mx, last_e.mn, last_e.amp}) begin
            errors++;
            $display("FAIL %s: results %0d/%0d/%0d/%0d/%0d changed",
                     name, period, high_cnt, peak_max, peak_min, amp_pp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: got %b want 000", {busy, done, timeout});
        end
        checks++;
        if ({period, high_cnt, peak_max, peak_min, amp_pp} !== 81'd0) begin
            errors++;
            $display("FAIL reset_results: got %0d/%0d/%0d/%0d/%0d want 0",
                     period, high_cnt, peak_max, peak_min, amp_pp);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_start();
        measure(16'sd100, -16'sd100, 10, 1'b0, 1'b0, 1);
        idle(3);
        check_dones("basic_done", 1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_hyst();
        int d0 = dones;
        cont = 1'b1;
        do_start();
        measure(16'sd1000, -16'sd1000, 16, 1'b1, 1'b0, 3);
        idle(3);
        check_dones("hyst_dones", d0 + 3);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_busy: got %b want 1", busy);
        end
        cont = 1'b0;
        do_abort();
    endtask

    task automatic test_gaps();
        int d0 = dones;
        cont = 1'b1;
        do_start();
        measure(16'sd100, -16'sd100, 10, 1'b0, 1'b1, 3);
        idle(3);
        check_dones("gaps_dones", d0 + 3);
        cont = 1'b0;
        do_abort();
    endtask

    task automatic test_fullscale();
        int d0 = dones;
        do_start();
        measure(16'sh7fff, -16'sh8000, 4, 1'b0, 1'b0, 1);
        idle(2);
        check_dones("full_done", d0 + 1);
        checks++;
        if (amp_pp !== 17'd65535) begin
            errors++;
            $display("FAIL full_amp: got %0d want 65535", amp_pp);
        end
    endtask

    task automatic test_timeout_arm();
        do_start();
        for (int i = 0; i < 63; i++) send(16'sd0, 1'b0);
        idle(1);
        checks++;
        if ({timeout, busy} !== 2'b01) begin
            errors++;
            $display("FAIL arm_pre_timeout: got t=%b b=%b want t=0 b=1",
                     timeout, busy);
        end
        send(16'sd0, 1'b0);
        idle(1);
        checks++;
        if ({timeout, busy} !== 2'b10) begin
            errors++;
            $display("FAIL arm_timeout: got t=%b b=%b want t=1 b=0",
                     timeout, busy);
        end
        check_held("arm_timeout_held");
        idle(1);
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got %b want 0", timeout);
        end
    endtask

    task automatic test_timeout_meas();
        do_start();
        for (int i = 0; i < 4; i++) send(-16'sd100, 1'b0);
        send(16'sd100, 1'b0);
        for (int i = 0; i < 62; i++) send(16'sd100, 1'b0);
        idle(1);
        checks++;
        if ({timeout, busy} !== 2'b01) begin
            errors++;
            $display("FAIL meas_pre_timeout: got t=%b b=%b want t=0 b=1",
                     timeout, busy);
        end
        send(16'sd100, 1'b0);
        idle(1);
        checks++;
        if ({timeout, busy} !== 2'b10) begin
            errors++;
            $display("FAIL meas_timeout: got t=%b b=%b want t=1 b=0",
                     timeout, busy);
        end
        check_held("meas_timeout_held");
    endtask

    task automatic test_abort();
        int d0 = dones;
        do_start();
        for (int i = 0; i < 10; i++) send(-16'sd100, 1'b0);
        gen_period(16'sd100, -16'sd100, 10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = 16'sd100;
        abort        = 1'b1;
        idle(1);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_close: got d=%b b=%b want 00", done, busy);
        end
        check_held("abort_held");
        idle(2);
        check_dones("abort_no_done", d0);
    endtask

    task automatic test_back_to_back_start();
        do_start();
        for (int i = 0; i < 4; i++) send(-16'sd100, 1'b0);
        for (int i = 0; i < 3; i++) send(16'sd100, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sample_valid = 1'b0;
        for (int i = 0; i < 3; i++) send(-16'sd100, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        sample_valid = 1'b0;
        #1;
        checks++;
        if ({busy, done, timeout, period, high_cnt, peak_max, peak_min,
             amp_pp} !== 84'd0) begin
            errors++;
            $display("FAIL reset_mid: got b=%b per=%0d amp=%0d want 0",
                     busy, period, amp_pp);
        end
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL after_reset: got b=%b d=%b want 00", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hyst();
        test_gaps();
        test_fullscale();
        test_timeout_arm();
        test_timeout_meas();
        test_abort();
        test_back_to_back_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
